// File: rtl/x2050tlat.sv
//------------------------------------------------------------------------------
// x2050tlat: T register, carry/overflow latches and a one-cycle decimal
// correction pass (optional, enabled by macro X2050_DEC_COR_EN).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module x2050tlat (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ros_advance,
  input  logic [3:0]  i_ad,
  input  logic        i_t_load,
  input  logic [31:0] i_t0,
  input  logic        i_c0,
  input  logic        i_c1,
  input  logic        i_c8,
  input  logic [32:0] i_dec_cor,
  input  logic        i_ovfl_clr,
  output logic [31:0] o_t,
  output logic        o_carry,
  output logic        o_ovfl,
  output logic        o_cor_sel,
  output logic [31:0] o_cor_y,
  output logic        o_stall
);

  localparam logic [3:0] AD_C0   = 4'd4;
  localparam logic [3:0] AD_XOR  = 4'd5;
  localparam logic [3:0] AD_C1   = 4'd6;
  localparam logic [3:0] AD_C8   = 4'd7;

  logic [31:0] t_reg;
  logic        carry;
  logic        carry_d;
  logic        ovfl;
  logic        in_cor;
  logic        adv_idle;
  logic        ovfl_set;

`ifdef X2050_DEC_COR_EN
  typedef enum logic {
    IDLE = 1'b0,
    COR  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] cor_reg;
  logic        start_cor;

  assign start_cor = i_ros_advance && i_t_load && i_dec_cor[0] && (state == IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      cor_reg <= '0;
    end else begin
      state <= state_d;
      if (start_cor)
        cor_reg <= i_dec_cor[32:1];
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_cor) state_d = COR;
      COR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_cor  = (state == COR);
  assign o_cor_y = in_cor ? cor_reg : 32'h0;
`else
  logic unused_dec_cor;

  assign unused_dec_cor = ^i_dec_cor;
  assign in_cor         = 1'b0;
  assign o_cor_y        = 32'h0;
`endif

  // An advance arriving during the correction pass is dropped entirely.
  assign adv_idle = i_ros_advance && !in_cor;
  assign ovfl_set = adv_idle && (i_ad == AD_XOR) && (i_c0 ^ i_c1);

  always_comb begin
    carry_d = carry;
    if (adv_idle) begin
      case (i_ad)
        AD_C0:   carry_d = i_c0;
        AD_XOR:  carry_d = i_c0 ^ i_c1;
        AD_C1:   carry_d = i_c1;
        AD_C8:   carry_d = i_c8;
        default: carry_d = carry;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      t_reg <= '0;
      carry <= 1'b0;
      ovfl  <= 1'b0;
    end else begin
      carry <= carry_d;
      if (in_cor || (adv_idle && i_t_load))
        t_reg <= i_t0;
      // Clear takes priority over a same-cycle set.
      if (i_ovfl_clr)
        ovfl <= 1'b0;
      else if (ovfl_set)
        ovfl <= 1'b1;
    end
  end

  assign o_t       = t_reg;
  assign o_carry   = carry;
  assign o_ovfl    = ovfl;
  assign o_cor_sel = in_cor;
  assign o_stall   = in_cor;

endmodule

`default_nettype wire

// File: tb/tb_x2050tlat.sv
//------------------------------------------------------------------------------
// tb_x2050tlat: directed vector table plus correction-pass/reset sequences.
//------------------------------------------------------------------------------
`default_nettype none

module tb_x2050tlat;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ros_advance = 1'b0;
  logic [3:0]  ad = 4'd0;
  logic        t_load = 1'b0;
  logic [31:0] t0 = 32'h0;
  logic        c0 = 1'b0, c1 = 1'b0, c8 = 1'b0;
  logic [32:0] dec_cor = 33'h0;
  logic        ovfl_clr = 1'b0;
  logic [31:0] t_out;
  logic        carry, ovfl, cor_sel, stall;
  logic [31:0] cor_y;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  x2050tlat dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_ros_advance (ros_advance),
    .i_ad          (ad),
    .i_t_load      (t_load),
    .i_t0          (t0),
    .i_c0          (c0),
    .i_c1          (c1),
    .i_c8          (c8),
    .i_dec_cor     (dec_cor),
    .i_ovfl_clr    (ovfl_clr),
    .o_t           (t_out),
    .o_carry       (carry),
    .o_ovfl        (ovfl),
    .o_cor_sel     (cor_sel),
    .o_cor_y       (cor_y),
    .o_stall       (stall)
  );

  typedef struct {
    logic        adv;
    logic [3:0]  ad;
    logic        tl;
    logic [31:0] t0;
    logic        c0, c1, c8;
    logic        clr;
    logic        cor;
    logic [31:0] exp_t;
    logic        exp_carry;
    logic        exp_ovfl;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ros_advance = 1'b0; t_load = 1'b0; ad = 4'd0;
    c0 = 1'b0; c1 = 1'b0; c8 = 1'b0; ovfl_clr = 1'b0; dec_cor = 33'h0;
  endtask

  // Drive the advance that launches a correction of 0xAA by 0x66.
  task automatic launch_cor();
    @(negedge clk);
    idle_inputs();
    ros_advance = 1'b1; t_load = 1'b1; t0 = 32'h0000_00AA;
    dec_cor = {32'h0000_0066, 1'b1};
    @(posedge clk); #1;
  endtask

  initial begin
    //             adv ad   tl t0            c0 c1 c8 clr cor exp_t         carry ovfl
    vecs[0]  = '{1'b1, 4'd0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd5, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 4'd4, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd6, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd7, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd3, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd5, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd5, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd4, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'd5, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 4'd4, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_t", t_out, 32'h0);
    check("reset_carry", {31'h0, carry}, 32'h0);
    check("reset_ovfl", {31'h0, ovfl}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_cor_sel", {31'h0, cor_sel}, 32'h0);
    check("reset_cor_y", cor_y, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: each row is one cycle of stimulus, checked just after the edge
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ros_advance = vecs[i].adv; ad = vecs[i].ad; t_load = vecs[i].tl; t0 = vecs[i].t0;
      c0 = vecs[i].c0; c1 = vecs[i].c1; c8 = vecs[i].c8; ovfl_clr = vecs[i].clr;
      dec_cor = {32'h0000_0099, vecs[i].cor};
      @(posedge clk); #1;
      check($sformatf("vec%0d_t", i), t_out, vecs[i].exp_t);
      check($sformatf("vec%0d_carry", i), {31'h0, carry}, {31'h0, vecs[i].exp_carry});
      check($sformatf("vec%0d_ovfl", i), {31'h0, ovfl}, {31'h0, vecs[i].exp_ovfl});
      check($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
    end

    // Correction pass: T gets 0xAA, then the corrected sum one cycle later
    launch_cor();
    check("cor_first_t", t_out, 32'h0000_00AA);
`ifdef X2050_DEC_COR_EN
    check("cor_stall", {31'h0, stall}, 32'h1);
    check("cor_sel", {31'h0, cor_sel}, 32'h1);
    check("cor_y", cor_y, 32'h0000_0066);
`else
    check("nocor_stall", {31'h0, stall}, 32'h0);
    check("nocor_sel", {31'h0, cor_sel}, 32'h0);
    check("nocor_y", cor_y, 32'h0);
`endif
    @(negedge clk);
    idle_inputs();
    t0 = 32'h0000_0110;
    @(posedge clk); #1;
`ifdef X2050_DEC_COR_EN
    check("cor_wb_t", t_out, 32'h0000_0110);
`else
    check("nocor_t", t_out, 32'h0000_00AA);
`endif
    check("cor_done_stall", {31'h0, stall}, 32'h0);
    check("cor_done_sel", {31'h0, cor_sel}, 32'h0);

    // Advance during the pass must not touch carry/overflow (carry is 0 here)
    launch_cor();
    @(negedge clk);
    idle_inputs();
    ros_advance = 1'b1; ad = 4'd4; c0 = 1'b1; t_load = 1'b1; t0 = 32'h0000_0110;
    @(posedge clk); #1;
`ifdef X2050_DEC_COR_EN
    check("cor_adv_carry", {31'h0, carry}, 32'h0);
`else
    check("nocor_adv_carry", {31'h0, carry}, 32'h1);
`endif
    check("cor_adv_ovfl", {31'h0, ovfl}, 32'h0);
    check("cor_adv_t", t_out, 32'h0000_0110);
    @(negedge clk);
    idle_inputs();
    t0 = 32'h5555_5555;
    @(posedge clk); #1;
    check("cor_adv_after_t", t_out, 32'h0000_0110);
    check("cor_adv_after_stall", {31'h0, stall}, 32'h0);

    // Reset mid-pass abandons the write-back
    launch_cor();
    @(negedge clk);
    idle_inputs();
    t0 = 32'h0000_0110;
    reset_n = 1'b0;
    #1;
    check("rst_mid_stall", {31'h0, stall}, 32'h0);
    check("rst_mid_sel", {31'h0, cor_sel}, 32'h0);
    check("rst_mid_t", t_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_t", t_out, 32'h0);
    check("rst_rel_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    check("rst_rel2_t", t_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
